// File: rtl/router_fsm_nch.sv
// Router control FSM: header decode, per-channel wait/load sequencing, drop/timeout handling.
// Decodes are combinational from state (0-cycle); holds in FIFO_FULL_STATE/WAIT_TILL_EMPTY while the destination stalls.
module router_fsm_nch #(
    parameter int NUM_CH   = 3,
    parameter int ADDR_W   = 2,
    parameter int WAIT_TMO = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] soft_reset,
    input  logic              fifo_full,
    input  logic              low_pkt_valid,
    input  logic              parity_done,
    output logic              busy,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              full_state,
    output logic              laf_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              drop_state,
    output logic              tmo_err,
    output logic [NUM_CH-1:0] ch_sel,
    output logic [7:0]        drop_cnt
);
    localparam int NSLOT = 1 << ADDR_W;
    localparam int CNT_W = (WAIT_TMO > 0) ? $clog2(WAIT_TMO + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = (WAIT_TMO > 0) ? CNT_W'(WAIT_TMO - 1) : '0;
    localparam logic [ADDR_W:0]  NCH_LIM  = (ADDR_W + 1)'(NUM_CH);

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        WAIT_TILL_EMPTY    = 4'd2,
        LOAD_DATA          = 4'd3,
        FIFO_FULL_STATE    = 4'd4,
        LOAD_AFTER_FULL    = 4'd5,
        LOAD_PARITY        = 4'd6,
        CHECK_PARITY_ERROR = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  addr;
    logic [CNT_W-1:0]   wait_cnt;
    logic [NSLOT-1:0]   empty_pad, sreset_pad;
    logic               addr_ok, in_pkt;

    // Widen per-channel vectors to the full address space so any addr indexes safely
    assign empty_pad  = NSLOT'(fifo_empty);
    assign sreset_pad = NSLOT'(soft_reset);
    assign addr_ok    = ({1'b0, data_in} < NCH_LIM);
    assign in_pkt     = (state != DECODE_ADDRESS) && (state != DROP_PACKET);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= DECODE_ADDRESS;
            addr     <= '0;
            wait_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == DECODE_ADDRESS && pkt_valid)
                addr <= data_in;
            wait_cnt <= (state == WAIT_TILL_EMPTY) ? wait_cnt + 1'b1 : '0;
            if (state_nx == DROP_PACKET && state != DROP_PACKET && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    always_comb begin
        state_nx = state;
        tmo_err  = 1'b0;
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (!addr_ok)
                        state_nx = DROP_PACKET;
                    else if (empty_pad[data_in])
                        state_nx = LOAD_FIRST_DATA;
                    else
                        state_nx = WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_nx = LOAD_DATA;
            WAIT_TILL_EMPTY: begin
                if (empty_pad[addr]) begin
                    state_nx = LOAD_FIRST_DATA;
                end else if (WAIT_TMO != 0 && wait_cnt == TMO_LAST) begin
                    state_nx = DROP_PACKET;
                    tmo_err  = 1'b1;
                end
            end
            LOAD_DATA: begin
                if (fifo_full)
                    state_nx = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    state_nx = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full)
                    state_nx = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    state_nx = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    state_nx = LOAD_PARITY;
                else
                    state_nx = LOAD_DATA;
            end
            LOAD_PARITY:        state_nx = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_nx = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            DROP_PACKET: begin
                if (!pkt_valid)
                    state_nx = DECODE_ADDRESS;
            end
            default: state_nx = DECODE_ADDRESS;
        endcase
        // A read-side abort on our own channel overrides everything, including a pending timeout
        if (in_pkt && sreset_pad[addr]) begin
            state_nx = DECODE_ADDRESS;
            tmo_err  = 1'b0;
        end
    end

    always_comb begin
        detect_add    = (state == DECODE_ADDRESS);
        lfd_state     = (state == LOAD_FIRST_DATA);
        ld_state      = (state == LOAD_DATA);
        full_state    = (state == FIFO_FULL_STATE);
        laf_state     = (state == LOAD_AFTER_FULL);
        rst_int_reg   = (state == CHECK_PARITY_ERROR);
        drop_state    = (state == DROP_PACKET);
        write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) || (state == LOAD_AFTER_FULL);
        busy          = (state == LOAD_FIRST_DATA) || (state == WAIT_TILL_EMPTY) ||
                        (state == FIFO_FULL_STATE) || (state == LOAD_AFTER_FULL) ||
                        (state == LOAD_PARITY)     || (state == CHECK_PARITY_ERROR);
        ch_sel        = '0;
        if (in_pkt && state <= DROP_PACKET)
            ch_sel = {{(NUM_CH-1){1'b0}}, 1'b1} << addr;
    end

endmodule

// File: tb/tb_router_fsm_nch.sv
// Directed packet scenarios plus a randomized phase, each cycle checked against a packet-level model.
// Outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
module tb_router_fsm_nch;
    localparam int NUM_CH   = 3;
    localparam int ADDR_W   = 2;
    localparam int WAIT_TMO = 64;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic pkt_valid, fifo_full, low_pkt_valid, parity_done;
    logic [ADDR_W-1:0] data_in;
    logic [NUM_CH-1:0] fifo_empty, soft_reset;
    logic busy, detect_add, lfd_state, ld_state, full_state, laf_state;
    logic write_enb_reg, rst_int_reg, drop_state, tmo_err;
    logic [NUM_CH-1:0] ch_sel;
    logic [7:0] drop_cnt;

    router_fsm_nch #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WAIT_TMO(WAIT_TMO)) dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_empty(fifo_empty), .soft_reset(soft_reset), .fifo_full(fifo_full),
        .low_pkt_valid(low_pkt_valid), .parity_done(parity_done), .busy(busy),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .full_state(full_state), .laf_state(laf_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .drop_state(drop_state), .tmo_err(tmo_err),
        .ch_sel(ch_sel), .drop_cnt(drop_cnt)
    );

    always #5 clock = ~clock;

    typedef enum int {S_DA, S_LFD, S_WTE, S_LD, S_FULL, S_LAF, S_LP, S_CPE, S_DROP, S_BAD} mst_t;

    mst_t m_st;
    int   m_addr, m_wait, m_drops;
    int   tests = 0;
    int   fails = 0;
    logic [9:0]        obs_dec;
    logic [NUM_CH-1:0] obs_ch;
    mst_t obs_st;
    mst_t trace[$];
    logic [NUM_CH-1:0] trace_ch[$];
    logic tmo_seen;
    mst_t seq_a[9];
    mst_t seq_b[9];
    mst_t seq_c[6];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {busy, detect_add, lfd, ld, full, laf, write_enb, rst_int, drop, tmo_err}
    function automatic logic [9:0] exp_dec(mst_t st, logic tmo);
        logic b, w;
        b = st inside {S_LFD, S_WTE, S_FULL, S_LAF, S_LP, S_CPE};
        w = st inside {S_LD, S_LP, S_LAF};
        return {b, st == S_DA, st == S_LFD, st == S_LD, st == S_FULL, st == S_LAF,
                w, st == S_CPE, st == S_DROP, tmo};
    endfunction

    function automatic mst_t obs_state(logic [9:0] d);
        if (d[8]) return S_DA;
        if (d[7]) return S_LFD;
        if (d[6]) return S_LD;
        if (d[5]) return S_FULL;
        if (d[4]) return S_LAF;
        if (d[2]) return S_CPE;
        if (d[1]) return S_DROP;
        if (d[9] && d[3]) return S_LP;
        if (d[9]) return S_WTE;
        return S_BAD;
    endfunction

    function automatic bit m_in_pkt();
        return !(m_st inside {S_DA, S_DROP});
    endfunction

    function automatic logic model_tmo();
        return (m_st == S_WTE) && !fifo_empty[m_addr] && !soft_reset[m_addr] && (m_wait == WAIT_TMO - 1);
    endfunction

    function automatic logic [NUM_CH-1:0] m_ch();
        logic [NUM_CH-1:0] v;
        v = '0;
        if (m_in_pkt()) v[m_addr] = 1'b1;
        return v;
    endfunction

    function automatic void m_reset();
        m_st = S_DA; m_addr = 0; m_wait = 0; m_drops = 0;
    endfunction

    function automatic void model_advance();
        mst_t nx;
        nx = m_st;
        if (m_in_pkt() && soft_reset[m_addr]) nx = S_DA;
        else begin
            case (m_st)
                S_DA: if (pkt_valid) begin
                    if (int'(data_in) >= NUM_CH) nx = S_DROP;
                    else if (fifo_empty[data_in]) nx = S_LFD;
                    else nx = S_WTE;
                end
                S_LFD:  nx = S_LD;
                S_WTE:  if (fifo_empty[m_addr]) nx = S_LFD;
                        else if (m_wait == WAIT_TMO - 1) nx = S_DROP;
                S_LD:   if (fifo_full) nx = S_FULL; else if (!pkt_valid) nx = S_LP;
                S_FULL: if (!fifo_full) nx = S_LAF;
                S_LAF:  nx = parity_done ? S_DA : (low_pkt_valid ? S_LP : S_LD);
                S_LP:   nx = S_CPE;
                S_CPE:  nx = fifo_full ? S_FULL : S_DA;
                S_DROP: if (!pkt_valid) nx = S_DA;
                default: nx = S_DA;
            endcase
        end
        if (m_st == S_DA && pkt_valid) m_addr = int'(data_in);
        if (nx == S_DROP && m_st != S_DROP && m_drops < 255) m_drops++;
        m_wait = (nx == S_WTE && m_st == S_WTE) ? m_wait + 1 : 0;
        m_st = nx;
    endfunction

    task automatic set_idle();
        pkt_valid = 1'b0; data_in = '0; fifo_empty = '1; soft_reset = '0;
        fifo_full = 1'b0; low_pkt_valid = 1'b0; parity_done = 1'b0;
    endtask

    task automatic step();
        @(negedge clock);
        obs_dec = {busy, detect_add, lfd_state, ld_state, full_state, laf_state,
                   write_enb_reg, rst_int_reg, drop_state, tmo_err};
        obs_ch  = ch_sel;
        obs_st  = obs_state(obs_dec);
        trace.push_back(obs_st);
        trace_ch.push_back(obs_ch);
        if (tmo_err) tmo_seen = 1'b1;
        check("decodes", obs_dec, exp_dec(m_st, model_tmo()));
        check("ch_sel", obs_ch, m_ch());
        check("drop_cnt", drop_cnt, m_drops);
        @(posedge clock);
        model_advance();
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_wait;
        logic got;
        set_idle();
        m_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset decodes", {busy, detect_add, lfd_state, ld_state, full_state, laf_state,
              write_enb_reg, rst_int_reg, drop_state, tmo_err}, 10'b01_0000_0000);
        check("reset ch_sel", ch_sel, 0);
        check("reset drop_cnt", drop_cnt, 0);
        reset = 1'b1;
        @(posedge clock); #1;

        // Basic packet to channel 1 with four payload-bearing load cycles
        seq_a = '{S_DA, S_LFD, S_LD, S_LD, S_LD, S_LD, S_LP, S_CPE, S_DA};
        trace.delete(); trace_ch.delete();
        pkt_valid = 1'b1; data_in = 2'd1; step();
        data_in = 2'd0;
        repeat (4) step();
        pkt_valid = 1'b0;
        repeat (4) step();
        foreach (seq_a[i]) check($sformatf("pkt seq[%0d]", i), trace[i], seq_a[i]);
        for (int i = 1; i < 8; i++) check($sformatf("pkt ch_sel[%0d]", i), trace_ch[i], 3'b010);

        // Channel 2 busy for ten wait cycles, then drains
        set_idle(); tmo_seen = 1'b0; trace.delete();
        fifo_empty = 3'b011; pkt_valid = 1'b1; data_in = 2'd2; step();
        data_in = 2'd0;
        repeat (9) step();
        fifo_empty = 3'b111; step();
        pkt_valid = 1'b0;
        repeat (5) step();
        n_wait = 0;
        foreach (trace[i]) if (trace[i] == S_WTE) n_wait++;
        check("wait cycles", n_wait, 10);
        check("wait exit to lfd", trace[11], S_LFD);
        check("wait no tmo", tmo_seen, 1'b0);

        // Channel 0 never drains: timeout, drop until pkt_valid falls
        set_idle(); tmo_seen = 1'b0;
        fifo_empty = 3'b110; pkt_valid = 1'b1; data_in = 2'd0; step();
        n_wait = 0; got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            step();
            n_wait++;
            got = obs_dec[0];
        end
        check("tmo seen", got, 1'b1);
        check("tmo wait cycles", n_wait, 64);
        repeat (3) begin
            step();
            check("tmo dropping", obs_st, S_DROP);
        end
        pkt_valid = 1'b0; step(); step();
        check("tmo back to decode", obs_st, S_DA);
        check("tmo drop_cnt", drop_cnt, 1);

        // Full during load, released after two full cycles
        seq_b = '{S_DA, S_LFD, S_LD, S_FULL, S_FULL, S_LAF, S_LP, S_CPE, S_DA};
        set_idle(); trace.delete();
        pkt_valid = 1'b1; step(); step();
        fifo_full = 1'b1; step(); step();
        fifo_full = 1'b0; low_pkt_valid = 1'b1; step();
        pkt_valid = 1'b0; repeat (4) step();
        foreach (seq_b[i]) check($sformatf("full seq[%0d]", i), trace[i], seq_b[i]);

        // Soft reset only honoured for the active channel
        seq_c = '{S_DA, S_LFD, S_LD, S_LD, S_LD, S_DA};
        set_idle(); trace.delete();
        pkt_valid = 1'b1; data_in = 2'd1; step(); step(); step();
        soft_reset = 3'b001; step();
        soft_reset = 3'b010; step();
        soft_reset = 3'b000; pkt_valid = 1'b0; step();
        foreach (seq_c[i]) check($sformatf("sreset seq[%0d]", i), trace[i], seq_c[i]);

        // Asynchronous reset in the middle of a packet
        set_idle();
        pkt_valid = 1'b1; data_in = 2'd2; step(); step();
        #2 reset = 1'b0;
        #1;
        check("async rst decodes", {busy, detect_add, lfd_state, ld_state, full_state, laf_state,
              write_enb_reg, rst_int_reg, drop_state, tmo_err}, 10'b01_0000_0000);
        check("async rst ch_sel", ch_sel, 0);
        check("async rst drop_cnt", drop_cnt, 0);
        m_reset(); set_idle();
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            pkt_valid     = ($urandom_range(0, 3) != 0);
            data_in       = ADDR_W'($urandom_range(0, 3));
            fifo_empty    = NUM_CH'($urandom);
            soft_reset    = ($urandom_range(0, 15) == 0) ? NUM_CH'($urandom) : '0;
            fifo_full     = ($urandom_range(0, 3) == 0);
            low_pkt_valid = $urandom_range(0, 1) != 0;
            parity_done   = $urandom_range(0, 1) != 0;
            step();
        end
        set_idle(); parity_done = 1'b1;
        repeat (10) step();
        check("drain to decode", obs_st, S_DA);

        // Illegal address drops until the counter saturates
        set_idle();
        repeat (300) begin
            pkt_valid = 1'b1; data_in = 2'd3; step();
            pkt_valid = 1'b0; step();
            check("bad addr drop", obs_st, S_DROP);
            check("bad addr busy", obs_dec[9], 1'b0);
        end
        step();
        check("drop_cnt saturated", drop_cnt, 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/router_fsm_nch.md
ROUTER_FSM_NCH -- requirements
Module: router_fsm_nch

Interface
REQ-001 Parameter NUM_CH, default 3, number of destination channels (legal 2..8).
REQ-002 Parameter ADDR_W, default 2, address field width; 2**ADDR_W >= NUM_CH SHALL hold.
REQ-003 Parameter WAIT_TMO, default 64, max cycles in WAIT_TILL_EMPTY before drop; 0 disables timeout.
REQ-004 clock  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 pkt_valid  in  1  source packet-valid.
REQ-007 data_in  in  ADDR_W  address field of header byte.
REQ-008 fifo_empty  in  NUM_CH  per-channel FIFO empty.
REQ-009 soft_reset  in  NUM_CH  per-channel soft reset from read-side timeout.
REQ-010 fifo_full, low_pkt_valid, parity_done  in  1 each  status from synchronizer/register block.
REQ-011 busy, detect_add, lfd_state, ld_state, full_state, laf_state, write_enb_reg, rst_int_reg  out  1 each  state decodes.
REQ-012 drop_state  out  1  FSM discarding current packet.
REQ-013 tmo_err  out  1  one-cycle pulse on wait timeout.
REQ-014 ch_sel  out  NUM_CH  one-hot destination of packet in flight.
REQ-015 drop_cnt  out  8  saturating count of dropped packets.

Function
REQ-016 States: DECODE_ADDRESS, LOAD_FIRST_DATA, WAIT_TILL_EMPTY, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, DROP_PACKET; unused encodings SHALL go to DECODE_ADDRESS.
REQ-017 addr register SHALL load data_in when state==DECODE_ADDRESS and pkt_valid; hold otherwise.
REQ-018 DECODE_ADDRESS: pkt_valid & data_in>=NUM_CH -> DROP_PACKET; pkt_valid & fifo_empty[data_in] -> LOAD_FIRST_DATA; pkt_valid & !fifo_empty[data_in] -> WAIT_TILL_EMPTY; else stay.
REQ-019 LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
REQ-020 WAIT_TILL_EMPTY: fifo_empty[addr] -> LOAD_FIRST_DATA; else WAIT_TMO!=0 and wait_cnt==WAIT_TMO-1 -> DROP_PACKET with tmo_err=1 that cycle; else stay; empty wins over timeout on same cycle.
REQ-021 wait_cnt SHALL clear on entry to WAIT_TILL_EMPTY and increment each cycle spent there; width clog2(WAIT_TMO+1).
REQ-022 LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
REQ-023 FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
REQ-024 LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else LOAD_DATA.
REQ-025 LOAD_PARITY -> CHECK_PARITY_ERROR; CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else DECODE_ADDRESS.
REQ-026 DROP_PACKET: !pkt_valid -> DECODE_ADDRESS; else stay; drop_cnt SHALL increment (saturate at 255) on each entry.
REQ-027 soft_reset[addr]=1 in any state other than DECODE_ADDRESS/DROP_PACKET SHALL force DECODE_ADDRESS next cycle; soft_reset on other channels SHALL be ignored.
REQ-028 busy=1 in LOAD_FIRST_DATA, WAIT_TILL_EMPTY, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR; 0 in DECODE_ADDRESS, LOAD_DATA, DROP_PACKET.
REQ-029 write_enb_reg=1 in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL only; rst_int_reg=1 in CHECK_PARITY_ERROR only; remaining decodes one-per-state, combinational from state.
REQ-030 ch_sel SHALL be one-hot of addr in all states except DECODE_ADDRESS and DROP_PACKET, where it is 0.

Reset
REQ-031 reset low SHALL asynchronously set state=DECODE_ADDRESS, addr=0, wait_cnt=0, drop_cnt=0; thus detect_add=1, all other outputs 0.
REQ-032 Reset asserted mid-packet SHALL abandon the packet without incrementing drop_cnt.

Verification
REQ-033 Header addr=1, fifo_empty=3'b111, 4 payload, pkt_valid low -> DECODE,LFD,LD x4,LP,CPE,DECODE; ch_sel=3'b010 during packet.
REQ-034 addr=2, fifo_empty[2]=0 for 10 cycles then 1, WAIT_TMO=64 -> WAIT_TILL_EMPTY 10 cycles, then LFD; tmo_err never set.
REQ-035 addr=0, fifo_empty[0] held 0, WAIT_TMO=64 -> tmo_err pulse after 64 cycles in wait, DROP_PACKET until pkt_valid low, drop_cnt=1.
REQ-036 addr=3 with NUM_CH=3 -> DROP_PACKET, busy=0, drop_cnt increments; 300 such packets -> drop_cnt=255.
REQ-037 fifo_full in LOAD_DATA, released 2 cycles later, low_pkt_valid=1, parity_done=0 -> FULL x2, LAF, LP, CPE.
REQ-038 soft_reset=3'b001 while addr=1 in LOAD_DATA -> no effect; soft_reset=3'b010 -> DECODE_ADDRESS next cycle.
